time_set_controller: RTL and testbench
======================================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 The block SHALL have parameter SEC_MAX, default 59, meaning the last seconds value before wrap.
REQ-002 The block SHALL have parameter MIN_MAX, default 59, meaning the last minutes value before wrap.
REQ-003 The block SHALL have parameter HR_MAX, default 11, meaning the last raw hours value before wrap; raw 0 displays as HR_MAX+1.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tick_1hz  input  1  one-cycle pulse marking one elapsed second.
REQ-008 btn_mode  input  1  one-cycle pulse (debounced upstream) that advances the mode.
REQ-009 btn_inc  input  1  one-cycle pulse (debounced upstream) that increments the selected field.
REQ-010 sec  output  6  seconds, 0..SEC_MAX, registered.
REQ-011 min  output  6  minutes, 0..MIN_MAX, registered.
REQ-012 hr_raw  output  7  raw hours, 0..HR_MAX, registered.
REQ-013 hr_disp  output  7  display hours: HR_MAX+1 when hr_raw==0, otherwise hr_raw; combinational from hr_raw.
REQ-014 pm  output  1  0=AM, 1=PM, registered.
REQ-015 mode  output  2  00=RUN, 01=SET_HR, 10=SET_MIN; 11 is never driven.
REQ-016 blink  output  1  display-blink enable for the selected field; 0 in RUN.

Function
REQ-017 The FSM SHALL have three states: RUN, SET_HR and SET_MIN.
REQ-018 On btn_mode, the FSM SHALL move RUN->SET_HR, SET_HR->SET_MIN and SET_MIN->RUN, taking effect on the next edge.
REQ-019 When the FSM enters SET_HR from RUN, sec SHALL be cleared to 0 on the same edge.
REQ-020 In RUN, each tick_1hz SHALL increment sec; sec SHALL wrap from SEC_MAX to 0 with a carry into min.
REQ-021 min SHALL wrap from MIN_MAX to 0 with a carry into hr_raw.
REQ-022 hr_raw SHALL wrap from HR_MAX to 0, and pm SHALL toggle on that wrap.
REQ-023 A full rollover (sec, min and hr_raw all at max) SHALL complete within one edge.
REQ-024 In RUN, btn_inc SHALL be ignored.
REQ-025 In SET_HR and SET_MIN, tick_1hz SHALL NOT advance sec, min or hr_raw; time is frozen.
REQ-026 In SET_HR, btn_inc SHALL increment hr_raw; the wrap from HR_MAX to 0 SHALL toggle pm. min SHALL be unchanged.
REQ-027 In SET_MIN, btn_inc SHALL increment min; the wrap from MIN_MAX to 0 SHALL NOT carry into hr_raw.
REQ-028 When btn_mode and btn_inc are asserted in the same cycle, btn_mode SHALL win and btn_inc SHALL be dropped.
REQ-029 In SET_HR and SET_MIN, blink SHALL toggle on each tick_1hz.
REQ-030 blink SHALL be forced to 0 on any mode transition and while in RUN.
REQ-031 Update latency SHALL be one edge: an input pulse in cycle n SHALL be visible on the outputs after edge n+1.
REQ-032 Input pulses held high for k cycles SHALL be treated as k separate events; the block performs no edge detection.
REQ-033 hr_raw, min and sec SHALL never hold an out-of-range value. Any illegal state encoding SHALL recover to RUN on the next edge.

Reset
REQ-034 While reset is high, the outputs SHALL asynchronously become: mode=RUN, sec=0, min=0, hr_raw=0 (so hr_disp=12), pm=0, blink=0.
REQ-035 Reset asserted mid-operation, including during a set mode, SHALL discard all state.
REQ-036 After reset deasserts, the first tick_1hz SHALL give sec=1.

Verification
REQ-037 Reset then no stimulus -> hr_disp=12, hr_raw=0, min=0, sec=0, pm=0, mode=00.
REQ-038 RUN at 11:59:59 AM (hr_raw=11, min=59, sec=59, pm=0) plus one tick -> hr_raw=0, hr_disp=12, min=0, sec=0, pm=1 after one edge.
REQ-039 btn_mode once, then btn_inc x13 -> mode=01, hr_raw=1, pm toggled once; ticks during this period leave sec=0 and toggle blink.
REQ-040 From SET_MIN with min=59, btn_inc -> min=0 and hr_raw unchanged; then btn_mode -> mode=00, blink=0, and ticks resume counting.
REQ-041 btn_mode and btn_inc asserted in the same cycle while in SET_HR -> mode=10 and hr_raw unchanged.
REQ-042 reset pulsed while in SET_MIN with min=30 -> outputs return to the reset values at once, without waiting for clk.

Source files
------------

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - 12-hour clock with RUN / SET_HR / SET_MIN editing modes
// Time fields, AM/PM, mode and blink are all registered; only hr_disp is decoded combinationally.
module time_set_controller #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [6:0] hr_raw,
  output logic [6:0] hr_disp,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t     r_state;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [6:0] r_hr;
  logic       r_pm;
  logic       r_blink;

  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hr_wrap;

  // Compare with >= so any out-of-range value is pulled back to 0 on its next increment.
  assign w_sec_wrap = (r_sec >= 6'(SEC_MAX));
  assign w_min_wrap = (r_min >= 6'(MIN_MAX));
  assign w_hr_wrap  = (r_hr >= 7'(HR_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_sec   <= 6'd0;
      r_min   <= 6'd0;
      r_hr    <= 7'd0;
      r_pm    <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_blink <= 1'b0;
          if (btn_mode) begin
            r_state <= SET_HR;
            r_sec   <= 6'd0;
          end else if (tick_1hz) begin
            if (w_sec_wrap) begin
              r_sec <= 6'd0;
              if (w_min_wrap) begin
                r_min <= 6'd0;
                if (w_hr_wrap) begin
                  r_hr <= 7'd0;
                  r_pm <= ~r_pm;
                end else begin
                  r_hr <= r_hr + 7'd1;
                end
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end
        end
        SET_HR: begin
          if (btn_mode) begin
            r_state <= SET_MIN;
            r_blink <= 1'b0;
          end else begin
            if (btn_inc) begin
              if (w_hr_wrap) begin
                r_hr <= 7'd0;
                r_pm <= ~r_pm;
              end else begin
                r_hr <= r_hr + 7'd1;
              end
            end
            if (tick_1hz) begin
              r_blink <= ~r_blink;
            end
          end
        end
        SET_MIN: begin
          if (btn_mode) begin
            r_state <= RUN;
            r_blink <= 1'b0;
          end else begin
            // Minute edits wrap locally and never carry into the hour.
            if (btn_inc) begin
              r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
            end
            if (tick_1hz) begin
              r_blink <= ~r_blink;
            end
          end
        end
        default: begin
          r_state <= RUN;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign hr_raw  = r_hr;
  assign pm      = r_pm;
  assign mode    = r_state;
  assign blink   = r_blink;
  assign hr_disp = (r_hr == 7'd0) ? 7'(HR_MAX + 1) : r_hr;

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - scoreboard bench for time_set_controller
// Expected outputs come from a seconds-of-day model, queued per driven cycle and popped after the edge.
module tb_time_set_controller;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 11;
  localparam int HALF_DAY = (HR_MAX + 1) * (MIN_MAX + 1) * (SEC_MAX + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [6:0] hr_raw;
  logic [6:0] hr_disp;
  logic       pm;
  logic [1:0] mode;
  logic       blink;

  time_set_controller #(
    .SEC_MAX(SEC_MAX),
    .MIN_MAX(MIN_MAX),
    .HR_MAX (HR_MAX)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .sec     (sec),
    .min     (min),
    .hr_raw  (hr_raw),
    .hr_disp (hr_disp),
    .pm      (pm),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int min;
    int hr;
    int pm;
    int mode;
    int blink;
  } snap_t;

  snap_t exp_q[$];
  int m_sec, m_min, m_hr, m_pm, m_mode, m_blink;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.sec = m_sec; s.min = m_min; s.hr = m_hr;
    s.pm = m_pm; s.mode = m_mode; s.blink = m_blink;
    return s;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_pm = 0; m_mode = 0; m_blink = 0;
  endtask

  // Model time as a position in a 24-hour cycle rather than a carry chain.
  task automatic model_step(input bit t, input bit m, input bit i);
    int tot;
    int h24;
    case (m_mode)
      0: begin
        m_blink = 0;
        if (m) begin
          m_mode = 1; m_sec = 0;
        end else if (t) begin
          tot = ((m_pm * (HR_MAX + 1) + m_hr) * (MIN_MAX + 1) + m_min) * (SEC_MAX + 1) + m_sec;
          tot = (tot + 1) % (2 * HALF_DAY);
          m_sec = tot % (SEC_MAX + 1);
          m_min = (tot / (SEC_MAX + 1)) % (MIN_MAX + 1);
          h24   = tot / ((SEC_MAX + 1) * (MIN_MAX + 1));
          m_hr  = h24 % (HR_MAX + 1);
          m_pm  = h24 / (HR_MAX + 1);
        end
      end
      1: begin
        if (m) begin
          m_mode = 2; m_blink = 0;
        end else begin
          if (i) begin
            h24 = (m_pm * (HR_MAX + 1) + m_hr + 1) % (2 * (HR_MAX + 1));
            m_hr = h24 % (HR_MAX + 1);
            m_pm = h24 / (HR_MAX + 1);
          end
          if (t) m_blink = 1 - m_blink;
        end
      end
      default: begin
        if (m) begin
          m_mode = 0; m_blink = 0;
        end else begin
          if (i) m_min = (m_min + 1) % (MIN_MAX + 1);
          if (t) m_blink = 1 - m_blink;
        end
      end
    endcase
  endtask

  task automatic compare_outputs(input string tag, input snap_t e);
    check({tag, ".sec"}, sec, e.sec);
    check({tag, ".min"}, min, e.min);
    check({tag, ".hr_raw"}, hr_raw, e.hr);
    check({tag, ".hr_disp"}, hr_disp, (e.hr == 0) ? HR_MAX + 1 : e.hr);
    check({tag, ".pm"}, pm, e.pm);
    check({tag, ".mode"}, mode, e.mode);
    check({tag, ".blink"}, blink, e.blink);
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
  task automatic step(input bit t, input bit m, input bit i);
    snap_t e;
    tick_1hz = t; btn_mode = m; btn_inc = i;
    model_step(t, m, i);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      compare_outputs("step", e);
    end
  endtask

  // Reset is raised between edges so the check observes the asynchronous path.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs(tag, model_snap());
    check({tag, ".hr_disp12"}, hr_disp, 12);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    apply_reset("reset_init");

    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    check("first_tick_sec", sec, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    check("run_inc_ignored_hr", hr_raw, 0);

    step(0, 1, 0);
    check("enter_set_hr_mode", mode, 1);
    check("enter_set_hr_sec", sec, 0);
    for (int k = 0; k < 13; k++) step((k % 2) == 0, 0, 1);
    check("set_hr_hr", hr_raw, 1);
    check("set_hr_pm", pm, 1);
    check("set_hr_sec_frozen", sec, 0);
    check("set_hr_blink", blink, 1);

    step(0, 1, 1);
    check("mode_wins_mode", mode, 2);
    check("mode_wins_hr", hr_raw, 1);
    check("mode_wins_blink", blink, 0);

    for (int k = 0; k < 59; k++) step(k % 3 == 0, 0, 1);
    check("set_min_59", min, 59);
    step(0, 0, 1);
    check("set_min_wrap", min, 0);
    check("set_min_no_carry", hr_raw, 1);

    step(0, 1, 0);
    check("back_run_mode", mode, 0);
    check("back_run_blink", blink, 0);
    repeat (3) step(1, 0, 0);
    check("run_resumes_sec", sec, 3);

    step(0, 1, 0);
    step(0, 1, 0);
    for (int k = 0; k < 30; k++) step(0, 0, 1);
    check("pre_reset_min", min, 30);
    apply_reset("reset_set_min");

    step(0, 1, 0);
    repeat (11) step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(1, 0, 0);
    check("pre_roll_hr", hr_raw, 11);
    check("pre_roll_min", min, 59);
    check("pre_roll_sec", sec, 59);
    check("pre_roll_pm", pm, 0);
    step(1, 0, 0);
    check("roll_hr", hr_raw, 0);
    check("roll_hr_disp", hr_disp, 12);
    check("roll_min", min, 0);
    check("roll_sec", sec, 0);
    check("roll_pm", pm, 1);
    step(1, 0, 0);
    check("post_roll_sec", sec, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
